// File: rtl/mod3_frame_tx.sv
// Serial frame transmitter: WIDTH payload bits MSB first, then two trailer
// bits chosen so that the number of ones in the whole frame is a multiple of 3.
module mod3_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bitCnt_q, bitCnt_d;
  logic [1:0]       onesMod_q, onesMod_d;
  logic             trailIdx_q, trailIdx_d;
  logic             done_q, done_d;
  logic [1:0]       onesModInc;

  assign onesModInc = (onesMod_q == 2'd2) ? 2'd0 : onesMod_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = DATA;
      DATA:    if (bit_en && (bitCnt_q == LAST_BIT)) state_d = TRAIL;
      TRAIL:   if (bit_en && trailIdx_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every datapath update is gated by bit_en so a stall of any length freezes the frame.
  always_comb begin
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    onesMod_d  = onesMod_q;
    trailIdx_d = trailIdx_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d    = in_data;
          bitCnt_d   = '0;
          onesMod_d  = 2'd0;
          trailIdx_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_en) begin
          shift_d  = {shift_q[WIDTH-2:0], 1'b0};
          bitCnt_d = (bitCnt_q == LAST_BIT) ? '0 : bitCnt_q + CW'(1);
          if (shift_q[WIDTH-1]) onesMod_d = onesModInc;
        end
      end
      TRAIL: begin
        if (bit_en) begin
          trailIdx_d = ~trailIdx_q;
          done_d     = trailIdx_q;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      bitCnt_q   <= '0;
      onesMod_q  <= 2'd0;
      trailIdx_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      onesMod_q  <= onesMod_d;
      trailIdx_q <= trailIdx_d;
      done_q     <= done_d;
    end
  end

  // Trailer: residue 0 -> 0,0; residue 1 -> 1,1; residue 2 -> 1,0.
  always_comb begin
    in_ready = 1'b0;
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    done     = done_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      DATA: begin
        tx_bit   = shift_q[WIDTH-1];
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      TRAIL: begin
        tx_bit   = trailIdx_q ? (onesMod_q == 2'd1) : (onesMod_q != 2'd0);
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mod3_frame_tx.sv
// Bench for mod3_frame_tx: queue-based frame model checked every cycle, plus
// directed frames whose serial sequences are pinned with literal values.
module tb_mod3_frame_tx;

  localparam int W         = 8;
  localparam int FRAME_LEN = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         bit_en;
  logic         tx_bit;
  logic         tx_valid;
  logic         busy;
  logic         done;

  mod3_frame_tx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .bit_en   (bit_en),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int enMode = 0;

  bit expBits[$];
  bit expDone = 1'b0;

  logic [31:0] curFrame = '0;
  logic [31:0] lastFrame = '0;
  int curLen = 0, lastLen = 0, curOnes = 0;
  int busyCycles = 0, lastBusy = 0;
  int doneCount = 0, sinceDone = 0, lastStartGap = -1;
  bit prevBusy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model frame: payload MSB first, then the fewest trailer ones that make the count divisible by 3.
  function automatic void loadFrame(input logic [W-1:0] d);
    int need;
    expBits.delete();
    for (int i = W - 1; i >= 0; i--) expBits.push_back(d[i]);
    need = (3 - ($countones(d) % 3)) % 3;
    case (need)
      0:       begin expBits.push_back(1'b0); expBits.push_back(1'b0); end
      1:       begin expBits.push_back(1'b1); expBits.push_back(1'b0); end
      default: begin expBits.push_back(1'b1); expBits.push_back(1'b1); end
    endcase
  endfunction

  // Bit strobe: mode 0 always high, mode 1 every third busy cycle, mode 2 random.
  initial begin
    int phase;
    phase  = 0;
    bit_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (enMode)
        0: bit_en = 1'b1;
        1: begin
          if (busy) begin
            bit_en = (phase % 3 == 2);
            phase++;
          end else begin
            bit_en = 1'b0;
            phase  = 0;
          end
        end
        default: bit_en = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Model advances on the edge, outputs are compared mid-cycle.
  initial begin
    logic e;
    forever begin
      @(posedge clk);
      if (rst) begin
        expBits.delete();
        expDone = 1'b0;
      end else begin
        expDone = 1'b0;
        if (expBits.size() == 0) begin
          if (in_valid) loadFrame(in_data);
        end else if (bit_en) begin
          void'(expBits.pop_front());
          if (expBits.size() == 0) expDone = 1'b1;
        end
      end
      @(negedge clk);
      if (rst) begin
        expBits.delete();
        expDone    = 1'b0;
        curFrame   = '0;
        curLen     = 0;
        curOnes    = 0;
        busyCycles = 0;
        prevBusy   = 1'b0;
      end
      e = (expBits.size() != 0) ? expBits[0] : 1'b0;
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expBits.size() == 0});
      checkOutput("tx_valid", {31'd0, tx_valid}, {31'd0, expBits.size() != 0});
      checkOutput("busy",     {31'd0, busy},     {31'd0, expBits.size() != 0});
      checkOutput("tx_bit",   {31'd0, tx_bit},   {31'd0, e});
      checkOutput("done",     {31'd0, done},     {31'd0, expDone});
      if (!rst) begin
        if (busy && !prevBusy) lastStartGap = sinceDone;
        if (busy) busyCycles++;
        if (done) begin
          doneCount++;
          lastFrame = curFrame;
          lastLen   = curLen;
          lastBusy  = busyCycles;
          checkOutput("mod3Detector", curOnes, 0);
          checkOutput("frameLen", curLen, FRAME_LEN);
          curFrame   = '0;
          curLen     = 0;
          curOnes    = 0;
          busyCycles = 0;
          sinceDone  = 0;
        end else begin
          sinceDone++;
        end
        if (tx_valid && bit_en) begin
          curFrame = {curFrame[30:0], tx_bit};
          curLen++;
          if (tx_bit) curOnes = (curOnes + 1) % 3;
        end
        prevBusy = busy;
      end
    end
  end

  task automatic startFrame(input logic [W-1:0] data, input bit hold);
    bit acc;
    acc      = 1'b0;
    in_data  = data;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("acceptTimeout", 32'd0, 32'd1);
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
    end
  endtask

  task automatic waitDone();
    int start;
    bit seen;
    start = doneCount;
    seen  = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (doneCount != start);
    end
    if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input int mode);
    enMode = mode;
    startFrame(data, 1'b0);
    waitDone();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int dc;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("rstTxValid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rstBusy",    {31'd0, busy},     32'd0);
    checkOutput("rstDone",    {31'd0, done},     32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(8'hFF, 0);
    checkOutput("seqFF", lastFrame, 32'h3FE);
    checkOutput("lenFF", lastLen, 32'd10);
    applyStimulus(8'h01, 0);
    checkOutput("seq01", lastFrame, 32'h007);
    applyStimulus(8'h07, 0);
    checkOutput("seq07", lastFrame, 32'h01C);
    applyStimulus(8'h00, 0);
    checkOutput("seq00", lastFrame, 32'h000);
    checkOutput("len00", lastLen, 32'd10);

    applyStimulus(8'hA5, 1);
    checkOutput("seqA5", lastFrame, 32'h297);
    checkOutput("busyA5", lastBusy, 32'd30);

    // Back-to-back: second word waits on the bus and is taken in the done cycle.
    enMode = 0;
    startFrame(8'h01, 1'b1);
    in_data = 8'hFF;
    waitDone();
    checkOutput("seqHold1", lastFrame, 32'h007);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    waitDone();
    checkOutput("seqHold2", lastFrame, 32'h3FE);
    checkOutput("gapHold", lastStartGap, 32'd0);

    // Abort mid-frame after four bits have gone out.
    enMode = 0;
    startFrame(8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    dc  = doneCount;
    @(negedge clk);
    checkOutput("abortTxValid", {31'd0, tx_valid}, 32'd0);
    checkOutput("abortBusy",    {31'd0, busy},     32'd0);
    checkOutput("abortTxBit",   {31'd0, tx_bit},   32'd0);
    checkOutput("abortReady",   {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("abortNoDone", doneCount, dc);
    applyStimulus(8'h03, 0);
    checkOutput("seq03", lastFrame, 32'h00E);

    for (int f = 0; f < 1000; f++) begin
      applyStimulus(W'($urandom), (f % 4 == 0) ? 0 : 2);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
